event_capture_fifo: RTL

EVENT_CAPTURE_FIFO -- requirements
Module: event_capture_fifo

---
 rtl/event_capture_fifo.sv | 137 +++++++++++++
 1 files changed

// File: rtl/event_capture_fifo.sv
// event_capture_fifo: synchronises an asynchronous event strobe from the filter
// stage, captures {pol, compout, timestamp} per rising edge into a
// first-word-fall-through FIFO, and flags dropped events with a sticky overflow.
// Optional feature: define EVT_TIMESTAMP_EN to build the free-running timestamp
// counter and store it per entry; otherwise the timestamp field reads 0.
module event_capture_fifo #(
    parameter int FIFO_DEPTH = 8,
    parameter int TS_WIDTH   = 12
) (
    input  logic                             wb_clk_i,
    input  logic                             wb_rst_i,
    input  logic                             enable,
    input  logic                             compout,
    input  logic                             pol,
    input  logic                             polxevent,
    output logic                             evt_valid,
    input  logic                             evt_ready,
    output logic [TS_WIDTH+1:0]              evt_data,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level,
    output logic                             overflow,
    input  logic                             clr_overflow
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [LW-1:0] LVL_ONE  = LW'(1);
    localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);
`ifdef EVT_TIMESTAMP_EN
    localparam int EW = TS_WIDTH + 2;
`else
    localparam int EW = 2;
`endif

    logic          comp_s1, comp_s2;
    logic          pol_s1, pol_s2;
    logic          evt_s1, evt_s2, evt_s3;
    logic [1:0]    flush_cnt;
    logic          armed;
    logic          detect;
    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0] wptr, rptr;
    logic [EW-1:0] entry_in;
    logic [EW-1:0] head;
    logic          empty, full, do_pop, do_push, drop;

    // Two-flop synchronisers for all filter-stage inputs, third flop on the strobe for edge detect
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            comp_s1 <= 1'b0;
            comp_s2 <= 1'b0;
            pol_s1  <= 1'b0;
            pol_s2  <= 1'b0;
            evt_s1  <= 1'b0;
            evt_s2  <= 1'b0;
            evt_s3  <= 1'b0;
        end else begin
            comp_s1 <= compout;
            comp_s2 <= comp_s1;
            pol_s1  <= pol;
            pol_s2  <= pol_s1;
            evt_s1  <= polxevent;
            evt_s2  <= evt_s1;
            evt_s3  <= evt_s2;
        end
    end

    // Arm edge detection only after a genuine low has passed the synchroniser, so a
    // strobe already high at reset release is not mistaken for a rising edge
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            flush_cnt <= 2'd0;
            armed     <= 1'b0;
        end else begin
            if (flush_cnt != 2'd2) flush_cnt <= flush_cnt + 2'd1;
            if (flush_cnt == 2'd2 && !evt_s2) armed <= 1'b1;
        end
    end

`ifdef EVT_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] ts;
    localparam logic [TS_WIDTH-1:0] TS_ONE = TS_WIDTH'(1);

    // Free-running timestamp, frozen while capture is disabled
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) ts <= '0;
        else if (enable) ts <= ts + TS_ONE;
    end

    assign entry_in = {pol_s2, comp_s2, ts};
    assign evt_data = empty ? '0 : head;
`else
    assign entry_in = {pol_s2, comp_s2};
    assign evt_data = empty ? '0 : {head, {TS_WIDTH{1'b0}}};
`endif

    assign head      = mem[rptr];
    assign evt_valid = ~empty;

    // Push/pop decisions; a full FIFO still accepts a push when the head leaves the same edge
    always_comb begin
        detect  = evt_s2 & ~evt_s3 & armed;
        empty   = (fifo_level == '0);
        full    = (fifo_level == LVL_FULL);
        do_pop  = ~empty & evt_ready;
        do_push = detect & enable & (~full | do_pop);
        drop    = detect & enable & full & ~do_pop;
    end

    // Entry storage; contents are only observable through the valid-gated head
    always_ff @(posedge wb_clk_i) begin
        if (do_push) mem[wptr] <= entry_in;
    end

    // Pointers wrap naturally at the power-of-two depth; level tracks push/pop exactly
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wptr       <= '0;
            rptr       <= '0;
            fifo_level <= '0;
        end else begin
            if (do_push) wptr <= wptr + PTR_ONE;
            if (do_pop)  rptr <= rptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   fifo_level <= fifo_level + LVL_ONE;
                2'b01:   fifo_level <= fifo_level - LVL_ONE;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // Sticky drop flag; a drop in the clearing cycle wins
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) overflow <= 1'b0;
        else if (drop) overflow <= 1'b1;
        else if (clr_overflow) overflow <= 1'b0;
    end
endmodule
